freg_read_unit: RTL and testbench

- Read side of the floating-point register array: accepts an instruction's source/destination specifiers, stalls on a scoreboard until every source (and the destination) is free of pending writes, then captures up to three 32-bit operands from the array outputs and presents them to the FPU with a valid/ready handshake.
- Owns the FP scoreboard. The scoreboard bit for rd is set at issue, and cleared by the same one-hot write-enable vector that drives the array's per-register enables.

---
 rtl/fp_pkg.sv | 24 ++
 rtl/freg_scoreboard.sv | 49 ++++
 rtl/freg_read_unit.sv | 173 +++++++++++++++++
 tb/tb_freg_read_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point register read path.
// Register file geometry, read-unit FSM states and the register slice helper.
package fp_pkg;

    localparam int FREG_N     = 32;
    localparam int FREG_W     = 32;
    localparam int FREG_IDX_W = 5;

    typedef logic [FREG_IDX_W-1:0] freg_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        OUT  = 2'd2
    } fsm_state_e;

    function automatic logic [FREG_W-1:0] freg_slice(
        input logic [FREG_N*FREG_W-1:0] flat,
        input freg_idx_t                idx
    );
        return flat[int'(idx)*FREG_W +: FREG_W];
    endfunction

endpackage

// File: rtl/freg_scoreboard.sv
// FP scoreboard: per-register pending-write bits, set at issue and
// cleared by the array write enables; set wins over a same-cycle clear.
module freg_scoreboard
    import fp_pkg::*;
#(
    parameter int NREG = FREG_N
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREG-1:0]       wb_en,
    input  logic                  set_en,
    input  logic [FREG_IDX_W-1:0] set_idx,
    input  logic [FREG_IDX_W-1:0] chk_rs1,
    input  logic [FREG_IDX_W-1:0] chk_rs2,
    input  logic [FREG_IDX_W-1:0] chk_rs3,
    input  logic [FREG_IDX_W-1:0] chk_rd,
    output logic [NREG-1:0]       busy,
    output logic                  haz_rs1,
    output logic                  haz_rs2,
    output logic                  haz_rs3,
    output logic                  haz_rd
);

    logic [NREG-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q & ~wb_en;
        if (set_en) begin
            busy_d[set_idx] = 1'b1;
        end
        // f0 is hardwired, so it can never be pending
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign haz_rs1 = busy_q[chk_rs1];
    assign haz_rs2 = busy_q[chk_rs2];
    assign haz_rs3 = busy_q[chk_rs3];
    assign haz_rd  = busy_q[chk_rd];

endmodule

// File: rtl/freg_read_unit.sv
// FP register read unit: captures a request, waits out scoreboard hazards,
// then presents up to three operands to the FPU under valid/ready.
module freg_read_unit
    import fp_pkg::*;
#(
    parameter int NREG   = FREG_N,
    parameter int W      = FREG_W,
    parameter int SCNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREG*W-1:0]     f_flat,
    input  logic [NREG-1:0]       wb_en,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [FREG_IDX_W-1:0] req_rs1,
    input  logic [FREG_IDX_W-1:0] req_rs2,
    input  logic [FREG_IDX_W-1:0] req_rs3,
    input  logic                  req_use_rs3,
    input  logic [FREG_IDX_W-1:0] req_rd,
    input  logic                  req_wr_rd,
    output logic                  op_valid,
    input  logic                  op_ready,
    output logic [W-1:0]          op_a,
    output logic [W-1:0]          op_b,
    output logic [W-1:0]          op_c,
    output logic [FREG_IDX_W-1:0] op_rd,
    output logic [NREG-1:0]       busy,
    output logic [SCNT_W-1:0]     stall_cnt
);

    fsm_state_e            state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  op_valid_q, op_valid_d;
    logic [W-1:0]          op_a_q, op_a_d;
    logic [W-1:0]          op_b_q, op_b_d;
    logic [W-1:0]          op_c_q, op_c_d;
    logic [FREG_IDX_W-1:0] op_rd_q, op_rd_d;
    logic [SCNT_W-1:0]     stall_q, stall_d;
    logic [FREG_IDX_W-1:0] rs1_q, rs1_d;
    logic [FREG_IDX_W-1:0] rs2_q, rs2_d;
    logic [FREG_IDX_W-1:0] rs3_q, rs3_d;
    logic [FREG_IDX_W-1:0] rd_q, rd_d;
    logic                  use_rs3_q, use_rs3_d;
    logic                  wr_rd_q, wr_rd_d;

    logic haz_rs1, haz_rs2, haz_rs3, haz_rd;
    logic hazard, set_en;

    freg_scoreboard #(.NREG(NREG)) u_sb (
        .clk     (clk),
        .reset   (reset),
        .wb_en   (wb_en),
        .set_en  (set_en),
        .set_idx (rd_q),
        .chk_rs1 (rs1_q),
        .chk_rs2 (rs2_q),
        .chk_rs3 (rs3_q),
        .chk_rd  (rd_q),
        .busy    (busy),
        .haz_rs1 (haz_rs1),
        .haz_rs2 (haz_rs2),
        .haz_rs3 (haz_rs3),
        .haz_rd  (haz_rd)
    );

    assign hazard = haz_rs1 | haz_rs2
                  | (use_rs3_q & haz_rs3)
                  | (wr_rd_q & haz_rd);

    assign set_en = (state_q == HOLD) && !hazard
                  && wr_rd_q && (rd_q != '0);

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        op_valid_d  = op_valid_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_c_d      = op_c_q;
        op_rd_d     = op_rd_q;
        stall_d     = stall_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rs3_d       = rs3_q;
        rd_d        = rd_q;
        use_rs3_d   = use_rs3_q;
        wr_rd_d     = wr_rd_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rs1_d       = req_rs1;
                    rs2_d       = req_rs2;
                    rs3_d       = req_rs3;
                    rd_d        = req_rd;
                    use_rs3_d   = req_use_rs3;
                    wr_rd_d     = req_wr_rd;
                    req_ready_d = 1'b0;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (hazard) begin
                    if (stall_q != '1) begin
                        stall_d = stall_q + 1'b1;
                    end
                end else begin
                    op_a_d     = freg_slice(f_flat, rs1_q);
                    op_b_d     = freg_slice(f_flat, rs2_q);
                    op_c_d     = freg_slice(f_flat, rs3_q);
                    op_rd_d    = rd_q;
                    op_valid_d = 1'b1;
                    state_d    = OUT;
                end
            end
            OUT: begin
                if (op_ready) begin
                    op_valid_d  = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                op_valid_d  = 1'b0;
                req_ready_d = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            op_valid_q  <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_c_q      <= '0;
            op_rd_q     <= '0;
            stall_q     <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rs3_q       <= '0;
            rd_q        <= '0;
            use_rs3_q   <= 1'b0;
            wr_rd_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            op_valid_q  <= op_valid_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_c_q      <= op_c_d;
            op_rd_q     <= op_rd_d;
            stall_q     <= stall_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rs3_q       <= rs3_d;
            rd_q        <= rd_d;
            use_rs3_q   <= use_rs3_d;
            wr_rd_q     <= wr_rd_d;
        end
    end

    assign req_ready = req_ready_q;
    assign op_valid  = op_valid_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_c      = op_c_q;
    assign op_rd     = op_rd_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_freg_read_unit.sv
// Bench for freg_read_unit: the bench plays the register array and checks
// the unit against a transaction-level scoreboard/operand model.
module tb_freg_read_unit;
    import fp_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic [1023:0] f_flat;
    logic [31:0]   wb_en;
    logic          req_valid;
    logic          req_ready;
    logic [4:0]    req_rs1, req_rs2, req_rs3, req_rd;
    logic          req_use_rs3, req_wr_rd;
    logic          op_valid, op_ready;
    logic [31:0]   op_a, op_b, op_c;
    logic [4:0]    op_rd;
    logic [31:0]   busy;
    logic [15:0]   stall_cnt;

    always #5 clk = ~clk;

    logic [31:0] mem [32];

    always_comb begin
        f_flat = '0;
        for (int i = 0; i < 32; i++) f_flat[i*32 +: 32] = mem[i];
    end

    freg_read_unit dut (
        .clk         (clk),
        .reset       (reset),
        .f_flat      (f_flat),
        .wb_en       (wb_en),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_rs3     (req_rs3),
        .req_use_rs3 (req_use_rs3),
        .req_rd      (req_rd),
        .req_wr_rd   (req_wr_rd),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_c        (op_c),
        .op_rd       (op_rd),
        .busy        (busy),
        .stall_cnt   (stall_cnt)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] m_busy;
    logic [15:0] m_stall;
    bit          rand_wb;
    int          rel_idx;
    int          rel_delay;
    logic [31:0] rel_val;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Write-enable pattern the bench-as-array drives this cycle.
    function automatic logic [31:0] gen_wb(input int n);
        logic [31:0] v;
        int          i;
        v = '0;
        if (rand_wb) begin
            if ($urandom_range(1) == 0) begin
                i = $urandom_range(31);
                if (m_busy != 0 && $urandom_range(3) != 0)
                    while (!m_busy[i]) i = $urandom_range(31);
                v[i] = 1'b1;
                if ($urandom_range(7) == 0) v[$urandom_range(31)] = 1'b1;
            end
        end else if (rel_idx >= 0 && rel_delay >= 0 && n == rel_delay) begin
            v[rel_idx] = 1'b1;
        end
        return v;
    endfunction

    task automatic step(input logic [31:0] wb, input logic [31:0] set);
        logic [31:0] val;
        wb_en = wb;
        @(posedge clk);
        #1;
        wb_en = '0;
        val = rand_wb ? $urandom : rel_val;
        for (int i = 1; i < 32; i++) if (wb[i]) mem[i] = val;
        if (reset) begin
            m_busy  = '0;
            m_stall = '0;
        end else begin
            m_busy    = (m_busy & ~wb) | set;
            m_busy[0] = 1'b0;
        end
    endtask

    task automatic run_req(input logic [4:0] r1, input logic [4:0] r2,
                           input logic [4:0] r3, input bit u3,
                           input logic [4:0] rd, input bit wr,
                           input int bp);
        logic [31:0] ea, eb, ec, wb, set;
        bit          haz, ok;
        int          n;
        chk("idle_req_ready", req_ready, 1);
        req_valid   = 1'b1;
        req_rs1     = r1;
        req_rs2     = r2;
        req_rs3     = r3;
        req_use_rs3 = u3;
        req_rd      = rd;
        req_wr_rd   = wr;
        step(gen_wb(-1), '0);
        req_valid   = 1'b0;
        req_rs1     = 5'($urandom);
        req_rs2     = 5'($urandom);
        req_rs3     = 5'($urandom);
        req_rd      = 5'($urandom);
        req_use_rs3 = 1'($urandom);
        req_wr_rd   = 1'($urandom);
        chk("accept_ready_low", req_ready, 0);
        chk("accept_no_valid", op_valid, 0);
        n  = 0;
        ok = 0;
        ea = '0; eb = '0; ec = '0;
        while (n <= 200) begin
            haz = m_busy[r1] | m_busy[r2] | (u3 & m_busy[r3])
                | (wr & m_busy[rd]);
            wb = gen_wb(n);
            if (!haz) begin
                ea  = mem[r1];
                eb  = mem[r2];
                ec  = mem[r3];
                set = '0;
                if (wr && rd != 0) set[rd] = 1'b1;
                step(wb, set);
                ok = 1;
                break;
            end
            if (m_stall != 16'hFFFF) m_stall++;
            step(wb, '0);
            n++;
            chk("hold_no_valid", op_valid, 0);
        end
        if (!ok) begin
            chk("stall_timeout", op_valid, 1);
            return;
        end
        chk("out_valid", op_valid, 1);
        chk("op_a", op_a, ea);
        chk("op_b", op_b, eb);
        chk("op_c", op_c, ec);
        chk("op_rd", op_rd, rd);
        chk("busy_issue", busy, m_busy);
        for (int k = 0; k < bp; k++) begin
            op_ready = 1'b0;
            step(gen_wb(-1), '0);
            chk("bp_valid", op_valid, 1);
            chk("bp_op_a", op_a, ea);
            chk("bp_op_c", op_c, ec);
            chk("bp_op_rd", op_rd, rd);
            chk("bp_req_ready", req_ready, 0);
        end
        op_ready = 1'b1;
        step(gen_wb(-1), '0);
        op_ready = 1'b0;
        chk("done_valid_low", op_valid, 0);
        chk("done_req_ready", req_ready, 1);
        chk("done_busy", busy, m_busy);
        chk("done_stall_cnt", stall_cnt, m_stall);
    endtask

    initial begin
        reset       = 1'b1;
        wb_en       = '0;
        req_valid   = 1'b0;
        req_rs1     = '0;
        req_rs2     = '0;
        req_rs3     = '0;
        req_rd      = '0;
        req_use_rs3 = 1'b0;
        req_wr_rd   = 1'b0;
        op_ready    = 1'b0;
        rand_wb     = 1'b0;
        rel_idx     = -1;
        rel_delay   = -1;
        rel_val     = '0;
        m_busy      = '0;
        m_stall     = '0;
        mem[0]      = '0;
        for (int i = 1; i < 32; i++) mem[i] = $urandom;
        step('0, '0);
        step('0, '0);
        reset = 1'b0;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_op_a", op_a, 0);
        chk("rst_op_b", op_b, 0);
        chk("rst_op_c", op_c, 0);
        chk("rst_op_rd", op_rd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall_cnt, 0);

        // no hazard
        mem[3] = 32'h3F800000;
        mem[4] = 32'h40000000;
        run_req(5'd3, 5'd4, 5'd0, 1'b0, 5'd5, 1'b1, 0);
        chk("nohaz_op_a", op_a, 32'h3F800000);
        chk("nohaz_busy5", busy[5], 1);

        // RAW on f5, released by a write of 3.0
        rel_idx   = 5;
        rel_delay = 3;
        rel_val   = 32'h40400000;
        run_req(5'd5, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 0);
        chk("raw_busy5_clear", busy[5], 0);
        chk("raw_stall_cnt", stall_cnt, 16'd4);

        // WAW on f7
        rel_idx = -1;
        run_req(5'd0, 5'd0, 5'd0, 1'b0, 5'd7, 1'b1, 0);
        rel_idx   = 7;
        rel_delay = 2;
        rel_val   = $urandom;
        run_req(5'd1, 5'd2, 5'd0, 1'b0, 5'd7, 1'b1, 0);
        chk("waw_stall_cnt", stall_cnt, 16'd7);
        rel_delay = 0;
        run_req(5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 0);
        chk("waw_busy7_clear", busy[7], 0);

        // rs3 only matters for FMA-class requests
        rel_idx = -1;
        run_req(5'd0, 5'd0, 5'd0, 1'b0, 5'd9, 1'b1, 0);
        run_req(5'd1, 5'd2, 5'd9, 1'b0, 5'd10, 1'b0, 0);
        chk("rs3_unused_no_stall", stall_cnt, 16'd7);
        rel_idx   = 9;
        rel_delay = 2;
        rel_val   = 32'hC0A00000;
        run_req(5'd1, 5'd2, 5'd9, 1'b1, 5'd0, 1'b0, 0);
        chk("rs3_used_stall", stall_cnt, 16'd10);
        chk("rs3_op_c", op_c, 32'hC0A00000);

        // backpressure
        rel_idx = -1;
        run_req(5'd3, 5'd4, 5'd5, 1'b1, 5'd11, 1'b1, 5);

        // index 0 and set-over-clear
        run_req(5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 0);
        chk("idx0_busy", busy, 32'h00000800);
        rel_idx   = 6;
        rel_delay = 0;
        rel_val   = $urandom;
        run_req(5'd1, 5'd2, 5'd0, 1'b0, 5'd6, 1'b1, 0);
        chk("set_prio_busy6", busy[6], 1);

        // reset while stalled
        rel_idx = -1;
        reset   = 1'b1;
        step('0, '0);
        reset   = 1'b0;
        run_req(5'd0, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 0);
        req_valid = 1'b1;
        req_rs1   = 5'd5;
        req_rs2   = 5'd0;
        req_rd    = 5'd0;
        req_wr_rd = 1'b0;
        req_use_rs3 = 1'b0;
        step('0, '0);
        req_valid = 1'b0;
        for (int k = 0; k < 12; k++) step('0, '0);
        chk("mid_stall_cnt", stall_cnt, 16'd12);
        chk("mid_busy", busy, 32'h00000020);
        reset = 1'b1;
        step('0, '0);
        reset = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_stall", stall_cnt, 0);
        chk("mid_rst_valid", op_valid, 0);
        chk("mid_rst_ready", req_ready, 1);

        // randomized traffic with random write-backs
        rand_wb = 1'b1;
        for (int t = 0; t < 40; t++) begin
            run_req(5'($urandom), 5'($urandom), 5'($urandom),
                    1'($urandom), 5'($urandom), 1'($urandom),
                    int'($urandom_range(3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
